// File: rtl/apb_master_if.sv
// Command/response channel and APB4 bus bundled between
// the apb_master requester and whatever sits on either side.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;

  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSELx;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH/8-1:0] PWSTRB;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    input  cmd_wstrb,
    output rsp_valid,
    input  rsp_ready,
    output rsp_rdata,
    output rsp_err,
    output rsp_timeout,
    output PADDR,
    output PSELx,
    output PENABLE,
    output PWRITE,
    output PWSTRB,
    output PWDATA,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR
  );

  modport slave (
    output cmd_valid,
    input  cmd_ready,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    output cmd_wstrb,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_rdata,
    input  rsp_err,
    input  rsp_timeout,
    input  PADDR,
    input  PSELx,
    input  PENABLE,
    input  PWRITE,
    input  PWSTRB,
    input  PWDATA,
    output PRDATA,
    output PREADY,
    output PSLVERR
  );

endinterface

// File: rtl/apb_master.sv
// APB4 requester: one command at a time through SETUP/ACCESS,
// PREADY wait bounded by a timeout, registered response channel.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          PCLK,
  input logic          PResetn,
  apb_master_if.master bus
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cmd_ready_q, cmd_ready_d;

  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]   pwstrb_q, pwstrb_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_to_q, rsp_to_d;

  always_ff @(posedge PCLK or negedge PResetn) begin
    if (!PResetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwstrb_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwstrb_q    <= pwstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwstrb_d    = pwstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;

    unique case (state_q)
      IDLE: begin
        // ready rises one cycle after reset release
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_wdata;
          pwstrb_d    = bus.cmd_write ?
                        bus.cmd_wstrb : '0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          rsp_to_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWSTRB      = pwstrb_q;
  assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: the bench plays the command
// source and the APB slave, checking every cycle of each transfer.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_bad;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK   (clk),
    .PResetn(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns #1 after the accepting edge.
  task automatic issue(input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~wr;
    bus.cmd_addr  = ~a;
    bus.cmd_wdata = ~d;
    bus.cmd_wstrb = ~s;
    chk("setup_psel", bus.PSELx, 1'b1);
    chk("setup_pen", bus.PENABLE, 1'b0);
    chk("setup_cmdrdy", bus.cmd_ready, 1'b0);
    chk("setup_paddr", bus.PADDR, a);
    chk("setup_pwrite", bus.PWRITE, wr);
    chk("setup_pwstrb", bus.PWSTRB, wr ? s : 4'h0);
  endtask

  // waits < 0 means the slave never raises PREADY.
  task automatic xfer(input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input int waits,
                      input logic [31:0] rd,
                      input logic err,
                      input logic [31:0] e_rdata,
                      input logic e_err,
                      input logic e_to,
                      input int e_lat);
    int cyc;
    bit done;
    issue(wr, a, d, s);
    bus.PREADY  = 1'b0;
    bus.PRDATA  = 32'hDEAD_BEEF;
    bus.PSLVERR = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (bus.rsp_valid) begin
        done = 1'b1;
      end else begin
        chk("acc_psel", bus.PSELx, 1'b1);
        chk("acc_pen", bus.PENABLE, 1'b1);
        chk("acc_paddr", bus.PADDR, a);
        chk("acc_pwrite", bus.PWRITE, wr);
        if (wr) chk("acc_pwdata", bus.PWDATA, d);
        chk("acc_pwstrb", bus.PWSTRB,
            wr ? s : 4'h0);
        if (waits >= 0 && cyc - 1 == waits) begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = rd;
          bus.PSLVERR = err;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PRDATA  = 32'hDEAD_BEEF;
          bus.PSLVERR = 1'b1;
        end
      end
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    chk("rsp_seen", done, 1'b1);
    chk("latency", cyc, e_lat);
    chk("rsp_psel", bus.PSELx, 1'b0);
    chk("rsp_pen", bus.PENABLE, 1'b0);
    chk("rsp_cmdrdy", bus.cmd_ready, 1'b0);
    chk("rsp_rdata", bus.rsp_rdata, e_rdata);
    chk("rsp_err", bus.rsp_err, e_err);
    chk("rsp_timeout", bus.rsp_timeout, e_to);
  endtask

  // Holds rsp_ready low for hold cycles while poking a
  // second command, then completes the handshake.
  task automatic drain(input int hold);
    logic [31:0] rdata0;
    logic err0;
    logic to0;
    rdata0 = bus.rsp_rdata;
    err0   = bus.rsp_err;
    to0    = bus.rsp_timeout;
    bus.rsp_ready = 1'b0;
    if (hold > 0) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h0000_0BAD;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rdata", bus.rsp_rdata, rdata0);
      chk("bp_err", bus.rsp_err, err0);
      chk("bp_to", bus.rsp_timeout, to0);
      chk("bp_cmdrdy", bus.cmd_ready, 1'b0);
      chk("bp_psel", bus.PSELx, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("hs_valid", bus.rsp_valid, 1'b0);
    chk("hs_cmdrdy", bus.cmd_ready, 1'b1);
    chk("hs_psel", bus.PSELx, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    repeat (3) tick();
    chk("rst_cmdrdy", bus.cmd_ready, 1'b0);
    chk("rst_psel", bus.PSELx, 1'b0);
    chk("rst_pen", bus.PENABLE, 1'b0);
    chk("rst_rspv", bus.rsp_valid, 1'b0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwstrb", bus.PWSTRB, 4'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_cmdrdy", bus.cmd_ready, 1'b1);
    chk("rel_psel", bus.PSELx, 1'b0);

    xfer(1'b1, 32'h4, 32'h2A, 4'h1, 0, 32'h0, 1'b0,
         32'h0, 1'b0, 1'b0, 2);
    drain(0);
    xfer(1'b0, 32'hC, 32'h0, 4'hF, 3, 32'h55, 1'b0,
         32'h55, 1'b0, 1'b0, 5);
    drain(0);
    xfer(1'b1, 32'h8, 32'h1234, 4'h3, 0, 32'h77, 1'b1,
         32'h0, 1'b1, 1'b0, 2);
    drain(0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b1,
         32'h1234_5678, 1'b1, 1'b0, 3);
    drain(0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, -1, 32'h0, 1'b0,
         32'h0, 1'b1, 1'b1, 17);
    drain(0);
    xfer(1'b1, 32'h24, 32'hCAFE_F00D, 4'hF, 15, 32'h0,
         1'b0, 32'h0, 1'b0, 1'b0, 17);
    drain(0);
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 0, 32'hA5A5_5A5A,
         1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0, 2);
    drain(5);
    xfer(1'b1, 32'h40, 32'h0000_0099, 4'h6, 0, 32'h0,
         1'b0, 32'h0, 1'b0, 1'b0, 2);
    drain(0);

    issue(1'b1, 32'h50, 32'h1111_2222, 4'hF);
    bus.PREADY = 1'b0;
    repeat (3) tick();
    chk("mid_pen", bus.PENABLE, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_psel", bus.PSELx, 1'b0);
    chk("arst_pen", bus.PENABLE, 1'b0);
    chk("arst_paddr", bus.PADDR, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_rspv", bus.rsp_valid, 1'b0);
      chk("post_rst_psel", bus.PSELx, 1'b0);
    end
    chk("post_rst_cmdrdy", bus.cmd_ready, 1'b1);
    bus.rsp_ready = 1'b0;

    xfer(1'b0, 32'h60, 32'h0, 4'h0, 2, 32'h0000_0042,
         1'b0, 32'h0000_0042, 1'b0, 1'b0, 4);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
